// File: rtl/uart_cfg_seq.sv
//------------------------------------------------------------------------------
// Module   : uart_cfg_seq
// Purpose  : Wishbone master that programs a 16550-style UART through a fixed
//            step table (read LC, set DLAB, divisor, LC, FC, read/modify IE).
//            Detects ack timeouts and supports re-configuration on a new
//            start pulse.
// Optional : `define UART_CFG_VERIFY_EN appends two read-back steps (LC, IE)
//            whose data is compared against the programmed values.
// Ports    : clk, rstn (async, active-low)
//            start_config   - start pulse, honoured in IDLE/DONE/ERROR
//            config_done    - sequence finished cleanly (held)
//            busy           - sequence in progress
//            cfg_error      - ack timeout or read-back mismatch (held)
//            err_step       - failing step index while cfg_error is high
//            wb_*           - Wishbone master (3-bit address, 8-bit data)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cfg_seq #(
  parameter logic [15:0] DIVISOR     = 16'h0082,
  parameter logic [7:0]  LCR_VALUE   = 8'h03,
  parameter logic [7:0]  FCR_VALUE   = 8'h00,
  parameter logic [7:0]  IER_VALUE   = 8'h01,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_config,
  output logic       config_done,
  output logic       busy,
  output logic       cfg_error,
  output logic [3:0] err_step,
  output logic [2:0] wb_address_o,
  output logic [7:0] wb_data_out_o,
  input  logic [7:0] wb_data_in_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic       wb_sel_o,
  input  logic       wb_ack_i
);

  // 16550 register map
  localparam logic [2:0] UART_REG_DL1 = 3'd0;
  localparam logic [2:0] UART_REG_DL2 = 3'd1;
  localparam logic [2:0] UART_REG_IE  = 3'd1;
  localparam logic [2:0] UART_REG_FC  = 3'd2;
  localparam logic [2:0] UART_REG_LC  = 3'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

`ifdef UART_CFG_VERIFY_EN
  localparam logic [3:0] LAST_STEP = 4'd9;
`else
  localparam logic [3:0] LAST_STEP = 4'd7;
`endif

  localparam logic [7:0] LCR_MASKED = LCR_VALUE & 8'h7F;

  // Counter must be able to hold ACK_TIMEOUT itself
  localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    step_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    rd_q;
  logic [3:0]    err_step_q;

  logic [2:0]    w_adr;
  logic          w_we;
  logic [7:0]    w_dat;
  logic          w_start_ok;
  logic          w_acc_done;
  logic          w_timeout;
  logic          w_last;
  logic          w_verify_fail;

`ifdef UART_CFG_VERIFY_EN
  logic [7:0]    ie_exp_q;
  logic          mism_q;
  assign w_verify_fail = mism_q;
`else
  assign w_verify_fail = 1'b0;
`endif

  assign w_start_ok = start_config &&
                      ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign w_acc_done = (state_q == S_REQ) && wb_ack_i;
  // An ack in the final allowed cycle takes priority over the timeout
  assign w_timeout  = (state_q == S_REQ) && !wb_ack_i && (tmo_q == TMO_LAST);
  assign w_last     = (step_q == LAST_STEP);

  // Step table: address, direction and write data for the current step
  always_comb begin
    w_adr = 3'd0;
    w_we  = 1'b0;
    w_dat = 8'h00;
    case (step_q)
      4'd0: begin w_adr = UART_REG_LC;  w_we = 1'b0; end
      4'd1: begin w_adr = UART_REG_LC;  w_we = 1'b1; w_dat = rd_q | 8'h80;  end
      4'd2: begin w_adr = UART_REG_DL2; w_we = 1'b1; w_dat = DIVISOR[15:8]; end
      4'd3: begin w_adr = UART_REG_DL1; w_we = 1'b1; w_dat = DIVISOR[7:0];  end
      4'd4: begin w_adr = UART_REG_LC;  w_we = 1'b1; w_dat = LCR_MASKED;    end
      4'd5: begin w_adr = UART_REG_FC;  w_we = 1'b1; w_dat = FCR_VALUE;     end
      4'd6: begin w_adr = UART_REG_IE;  w_we = 1'b0; end
      4'd7: begin w_adr = UART_REG_IE;  w_we = 1'b1; w_dat = rd_q | IER_VALUE; end
`ifdef UART_CFG_VERIFY_EN
      4'd8: begin w_adr = UART_REG_LC;  w_we = 1'b0; end
      4'd9: begin w_adr = UART_REG_IE;  w_we = 1'b0; end
`endif
      default: begin w_adr = 3'd0; w_we = 1'b0; w_dat = 8'h00; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_config) state_d = S_REQ;
      end
      S_REQ: begin
        if (wb_ack_i)       state_d = S_GAP;
        else if (w_timeout) state_d = S_ERROR;
      end
      S_GAP: begin
        if (w_verify_fail)  state_d = S_ERROR;
        else if (w_last)    state_d = S_DONE;
        else                state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: bus signals are forced to zero whenever no strobe is active
  always_comb begin
    wb_cyc_o      = (state_q == S_REQ);
    wb_stb_o      = (state_q == S_REQ);
    wb_we_o       = (state_q == S_REQ) ? w_we  : 1'b0;
    wb_address_o  = (state_q == S_REQ) ? w_adr : 3'd0;
    wb_data_out_o = (state_q == S_REQ) ? w_dat : 8'h00;
    wb_sel_o      = 1'b1;
    busy          = (state_q == S_REQ) || (state_q == S_GAP);
    config_done   = (state_q == S_DONE);
    cfg_error     = (state_q == S_ERROR);
    err_step      = err_step_q;
  end

  // Datapath registers: step index, timeout counter, read data, error step
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_q     <= 4'd0;
      tmo_q      <= '0;
      rd_q       <= 8'h00;
      err_step_q <= 4'd0;
`ifdef UART_CFG_VERIFY_EN
      ie_exp_q   <= 8'h00;
      mism_q     <= 1'b0;
`endif
    end else begin
      // Counter restarts every time REQ is entered
      if (state_q != S_REQ) begin
        tmo_q <= '0;
      end else if (!wb_ack_i) begin
        tmo_q <= tmo_q + TW'(1);
      end

      if (w_start_ok) begin
        step_q     <= 4'd0;
        rd_q       <= 8'h00;
        err_step_q <= 4'd0;
`ifdef UART_CFG_VERIFY_EN
        mism_q     <= 1'b0;
`endif
      end else begin
        if ((state_q == S_GAP) && !w_verify_fail && !w_last) begin
          step_q <= step_q + 4'd1;
        end
        if (w_acc_done && !w_we) begin
          rd_q <= wb_data_in_i;
        end
        if (w_timeout || ((state_q == S_GAP) && w_verify_fail)) begin
          err_step_q <= step_q;
        end
`ifdef UART_CFG_VERIFY_EN
        if (w_acc_done && (step_q == 4'd7)) begin
          ie_exp_q <= w_dat;
        end
        // Mismatch is latched on the read ack and acted on in the following GAP
        if (state_q == S_GAP) begin
          mism_q <= 1'b0;
        end else if (w_acc_done && (step_q == 4'd8)) begin
          mism_q <= (wb_data_in_i != LCR_MASKED);
        end else if (w_acc_done && (step_q == 4'd9)) begin
          mism_q <= (wb_data_in_i != ie_exp_q);
        end
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cfg_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_cfg_seq
// Purpose  : Directed bench for uart_cfg_seq with a programmable-wait
//            Wishbone slave model (per-access read data table, optional
//            never-acked access). Build with +define+UART_CFG_VERIFY_EN to
//            cover the read-back steps.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_cfg_seq;

`ifdef UART_CFG_VERIFY_EN
  localparam int NST = 10;
`else
  localparam int NST = 8;
`endif
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_config;
  logic       config_done, busy, cfg_error;
  logic [3:0] err_step;
  logic [2:0] wb_address_o;
  logic [7:0] wb_data_out_o;
  logic [7:0] wb_data_in_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o, wb_ack_i;

  always #5 clk = ~clk;

  uart_cfg_seq #(.ACK_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_config (start_config),
    .config_done  (config_done),
    .busy         (busy),
    .cfg_error    (cfg_error),
    .err_step     (err_step),
    .wb_address_o (wb_address_o),
    .wb_data_out_o(wb_data_out_o),
    .wb_data_in_i (wb_data_in_i),
    .wb_we_o      (wb_we_o),
    .wb_stb_o     (wb_stb_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_sel_o     (wb_sel_o),
    .wb_ack_i     (wb_ack_i)
  );

  // Slave model
  logic [7:0] rtab [0:31];
  logic [7:0] wait_cyc;
  logic [4:0] hang_step;
  logic [4:0] acc;
  logic [7:0] wcnt;
  logic       acc_clr;
  int         cyc_n;

  assign wb_ack_i     = wb_cyc_o && wb_stb_o && (wcnt >= wait_cyc) && (acc != hang_step);
  assign wb_data_in_i = (wb_stb_o && !wb_we_o) ? rtab[acc] : 8'h00;

  initial begin
    acc   = 5'd0;
    wcnt  = 8'd0;
    cyc_n = 0;
  end

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wcnt <= wcnt + 8'd1;
    else                                   wcnt <= 8'd0;
    if (acc_clr)                           acc <= 5'd0;
    else if (wb_cyc_o && wb_stb_o && wb_ack_i) acc <= acc + 5'd1;
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [11:0] log_q [0:15];
  int         nlog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Compare logged accesses against hand-written step table
  task automatic check_log(input logic [7:0] lc, input logic [7:0] ie);
    logic [11:0] e [0:9];
    e[0] = {3'd3, 1'b0, 8'h00};
    e[1] = {3'd3, 1'b1, lc | 8'h80};
    e[2] = {3'd1, 1'b1, 8'h00};
    e[3] = {3'd0, 1'b1, 8'h82};
    e[4] = {3'd3, 1'b1, 8'h03};
    e[5] = {3'd2, 1'b1, 8'h00};
    e[6] = {3'd1, 1'b0, 8'h00};
    e[7] = {3'd1, 1'b1, ie | 8'h01};
    e[8] = {3'd3, 1'b0, 8'h00};
    e[9] = {3'd1, 1'b0, 8'h00};
    check("access_count", 32'(nlog), 32'(NST));
    for (int k = 0; k < NST; k++)
      check($sformatf("access%0d", k), 32'(log_q[k]), 32'(e[k]));
  endtask

  task automatic run_seq(input logic [7:0] wt, input logic [4:0] hang, input int mid_pulse,
                         output int t_end, output int nreq_hang);
    int s;
    wait_cyc  = wt;
    hang_step = hang;
    nlog      = 0;
    t_end     = -1;
    nreq_hang = 0;
    @(negedge clk);
    start_config = 1'b1;
    acc_clr      = 1'b1;
    s            = cyc_n;
    @(negedge clk);
    start_config = 1'b0;
    acc_clr      = 1'b0;
    for (int i = 1; i < 400; i++) begin
      start_config = (i == mid_pulse);
      if (config_done || cfg_error) begin
        t_end = cyc_n - s;
        break;
      end
      check("busy", 32'(busy), 32'd1);
      if (!wb_stb_o)
        check("idle_bus", 32'({wb_address_o, wb_we_o, wb_data_out_o}), 32'd0);
      if (wb_stb_o && wb_ack_i && nlog < 16) begin
        log_q[nlog] = {wb_address_o, wb_we_o, wb_we_o ? wb_data_out_o : 8'h00};
        nlog++;
      end
      if (wb_stb_o && acc == hang) nreq_hang++;
      @(negedge clk);
    end
    start_config = 1'b0;
    if (t_end < 0) check("seq_end", 32'({config_done, cfg_error}), 32'd2);
  endtask

  initial begin
    int t, h;
    rstn         = 1'b0;
    start_config = 1'b0;
    acc_clr      = 1'b0;
    wait_cyc     = 8'd0;
    hang_step    = 5'h1f;
    nlog         = 0;
    for (int k = 0; k < 32; k++) rtab[k] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_status", 32'({config_done, busy, cfg_error, err_step}), 32'd0);
    check("rst_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_address_o, wb_data_out_o}), 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", 32'({config_done, busy, cfg_error, wb_cyc_o}), 32'd0);

    // Zero-wait slave, LC/IE read 0
    rtab[8] = 8'h03; rtab[9] = 8'h01;
    run_seq(8'd0, 5'h1f, 0, t, h);
    check("zw_latency", 32'(t), 32'(NST * 2 + 1));
    check("zw_done", 32'({config_done, cfg_error, busy}), 32'b100);
    check_log(8'h00, 8'h00);
    repeat (5) @(negedge clk);
    check("zw_done_held", 32'({config_done, wb_cyc_o}), 32'b10);

    // Three-wait slave
    run_seq(8'd3, 5'h1f, 0, t, h);
    check("w3_latency", 32'(t), 32'(NST * 5 + 1));
    check("w3_done", 32'({config_done, cfg_error}), 32'b10);
    check_log(8'h00, 8'h00);

    // Timeout on step 2
    run_seq(8'd0, 5'd2, 0, t, h);
    check("tmo_latency", 32'(t), 32'd13);
    check("tmo_req_cycles", 32'(h), 32'(TMO));
    check("tmo_status", 32'({config_done, cfg_error, busy}), 32'b010);
    check("tmo_err_step", 32'(err_step), 32'd2);
    check("tmo_accesses", 32'(nlog), 32'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("tmo_quiet", 32'({wb_cyc_o, wb_stb_o, cfg_error}), 32'b001);
    end
    run_seq(8'd0, 5'h1f, 0, t, h);
    check("restart_latency", 32'(t), 32'(NST * 2 + 1));
    check("restart_status", 32'({config_done, cfg_error, err_step}), 32'b10_0000);
    check_log(8'h00, 8'h00);

    // IE reads 04 -> IE write 05, LC read 21 -> LC write A1
    rtab[0] = 8'h21; rtab[6] = 8'h04; rtab[9] = 8'h05;
    run_seq(8'd0, 5'h1f, 0, t, h);
    check("ie_done", 32'({config_done, cfg_error}), 32'b10);
    check_log(8'h21, 8'h04);

`ifdef UART_CFG_VERIFY_EN
    // LC read-back mismatch
    rtab[0] = 8'h00; rtab[6] = 8'h00; rtab[8] = 8'h83; rtab[9] = 8'h01;
    run_seq(8'd0, 5'h1f, 0, t, h);
    check("vfy_lc_latency", 32'(t), 32'd19);
    check("vfy_lc_status", 32'({config_done, cfg_error}), 32'b01);
    check("vfy_lc_err_step", 32'(err_step), 32'd8);
    // IE read-back mismatch
    rtab[8] = 8'h03; rtab[9] = 8'h00;
    run_seq(8'd0, 5'h1f, 0, t, h);
    check("vfy_ie_status", 32'({config_done, cfg_error}), 32'b01);
    check("vfy_ie_err_step", 32'(err_step), 32'd9);
    rtab[9] = 8'h01;
`else
    rtab[0] = 8'h00; rtab[6] = 8'h00; rtab[9] = 8'h01;
`endif

    // Asynchronous reset during step 3 REQ
    wait_cyc  = 8'd3;
    hang_step = 5'h1f;
    @(negedge clk);
    start_config = 1'b1;
    acc_clr      = 1'b1;
    @(negedge clk);
    start_config = 1'b0;
    acc_clr      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (acc == 5'd3 && wb_stb_o) break;
      @(negedge clk);
    end
    check("rst_reach_step3", 32'({acc, wb_stb_o}), 32'({5'd3, 1'b1}));
    rstn = 1'b0;
    #1;
    check("arst_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_address_o, wb_data_out_o}), 32'd0);
    check("arst_status", 32'({config_done, busy, cfg_error, err_step}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("arst_idle", 32'({busy, wb_cyc_o}), 32'd0);
    run_seq(8'd0, 5'h1f, 6, t, h);
    check("post_rst_latency", 32'(t), 32'(NST * 2 + 1));
    check("post_rst_done", 32'({config_done, cfg_error}), 32'b10);
    check_log(8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_cfg_seq.md
# uart_cfg_seq

Parametrised UART configuration sequencer; next generation of the fixed-value UART config FSM. Wishbone master that programs the 16550-style UART core through a fixed step table of reads, read-modify-writes and writes, with divisor, line-control, FIFO-control and interrupt-enable values set by parameters. Adds ack-timeout error detection, re-configuration on a new start pulse, and optional read-back verification. Sits between the gateway control logic and the UART core's Wishbone slave port.

## Interface
- `DIVISOR`, 16'h0082: baud divisor; `[15:8]` goes to DL2, `[7:0]` to DL1.
- `LCR_VALUE`, 8'h03: final line-control value; bit 7 (DLAB) is always forced to 0 in the written value.
- `FCR_VALUE`, 8'h00: FIFO-control value.
- `IER_VALUE`, 8'h01: interrupt-enable bits, ORed into the current IE contents.
- `ACK_TIMEOUT`, 64: maximum cycles a request may wait for ack; must be at least 2.

Ports:
- `clk` in 1: sole clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `start_config` in 1: start pulse; sampled only in IDLE, DONE or ERROR.
- `config_done` out 1: sequence completed without error; held until the next accepted start.
- `busy` out 1: high from the cycle after an accepted start until DONE or ERROR.
- `cfg_error` out 1: ack timeout or verify mismatch; held until the next accepted start.
- `err_step` out 4: step index at which the error occurred; valid while `cfg_error` is high.
- `wb_master` (wishbone.master): address[2:0], data_out[7:0], data_in[7:0], we, stb, cyc, sel, ack.

## Operation
- Register addresses come from `UART_REG_*` in uart_defines.v.
- `sel` is tied to all-ones.
- `rd` is an 8-bit register loaded from `data_in` on ack of any read step.
- Step table:
  - 0: read LC.
  - 1: write LC = rd|8'h80.
  - 2: write DL2 = DIVISOR[15:8].
  - 3: write DL1 = DIVISOR[7:0].
  - 4: write LC = LCR_VALUE&8'h7F.
  - 5: write FC = FCR_VALUE.
  - 6: read IE.
  - 7: write IE = rd|IER_VALUE; this value is also stored in `ie_exp`.
  - 8 and 9 exist only with the macro; see Configuration.
- States:
  - IDLE: on `start_config` → REQ, step = 0. Also clears `config_done`, `cfg_error`, `rd` and the timeout counter.
  - REQ: `cyc`=`stb`=1; `address`, `we` and `data_out` come from the step table. On `ack` → GAP. If no ack in ACK_TIMEOUT cycles → ERROR.
  - GAP: `cyc`=`stb`=`we`=0 for one cycle. Then → REQ with step+1, or → DONE if the last step has completed.
  - DONE: `config_done`=1. `start_config` → REQ at step 0 (full re-configuration).
  - ERROR: `cfg_error`=1 and `err_step` holds the failing step. `start_config` → REQ at step 0.
- `start_config` is ignored in REQ and GAP.
- Whenever `stb`=0, `data_out`, `address` and `we` are driven to 0.

## Timing
- Reset values: all Wishbone outputs 0 (`sel`=1), `config_done`=0, `busy`=0, `cfg_error`=0, `err_step`=0, `rd`=0, state IDLE.
- Ack is used combinationally in the same cycle (no sampled-ack delay).
- Each step takes 1 + L cycles in REQ, where L is the number of cycles before ack, plus 1 GAP cycle.
- With a zero-wait slave (ack in the first REQ cycle), 8 steps take 16 cycles. `config_done` rises 17 cycles after the `start_config` cycle.
- Timeout:
  - The counter resets on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches ACK_TIMEOUT with no ack, `cyc`/`stb` drop the next cycle and the state becomes ERROR.
  - Ack arriving in that same final cycle wins: the step completes normally.
- Reset mid-transaction: `cyc`/`stb` drop immediately (asynchronous) and the state returns to IDLE.
- An ack arriving outside REQ is ignored.

## Configuration
- `UART_CFG_VERIFY_EN` defined: steps 8 and 9 are appended.
  - 8: read LC; compare against LCR_VALUE&8'h7F.
  - 9: read IE; compare against `ie_exp`.
  - A mismatch → ERROR with `err_step` = 8 or 9, entered after the GAP cycle.
  - Zero-wait total: 20 cycles.
- Not defined: the sequence ends after step 7, and no compare logic or `ie_exp` register is built.

## Test plan
- Zero-wait slave, defaults, LC reads 8'h00, IE reads 8'h00:
  - Write sequence: LC←8'h80, DL2←8'h00, DL1←8'h82, LC←8'h03, FC←8'h00, IE←8'h01.
  - `config_done` rises at cycle 17.
- Slave with 3-wait ack on every access: each step takes 5 cycles; data and order unchanged; `busy` stays high throughout.
- Slave never acks step 2, ACK_TIMEOUT=8:
  - `cyc` drops after 8 REQ cycles; `cfg_error`=1, `err_step`=2; no further requests.
  - A new `start_config` restarts cleanly at step 0.
- IE reads 8'h04, IER_VALUE=8'h01: IE write is 8'h05. With `UART_CFG_VERIFY_EN`, slave returns 8'h05 on step 9 → `config_done`=1.
- `UART_CFG_VERIFY_EN`, LC read-back 8'h83: `cfg_error`=1, `err_step`=8.
- `rstn` asserted during step 3 REQ: outputs return to reset values that same cycle. Start after release → full sequence from step 0; `start_config` pulsed mid-run is ignored.
